// File: rtl/sprite_tile_fetcher_pkg.sv
// Shared PPU definitions for the sprite tile fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_tile_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_LO = 2'd1,
    ST_RD_HI = 2'd2,
    ST_LOAD  = 2'd3
  } fetch_state_e;

  // OAM attribute byte bit positions
  localparam int ATTR_PRIO  = 7;
  localparam int ATTR_YFLIP = 6;
  localparam int ATTR_XFLIP = 5;
  localparam int ATTR_PAL   = 4;

  // Tile-data byte address width (offset from 0x8000)
  localparam int VRAM_AW = 13;

  // Mirror a pixel row so the leftmost pixel becomes the rightmost
  function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_tile_addr.sv
// Tile-data address generator: row select with Y-flip, 8x16 tile pairing, plane bit.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module sprite_tile_addr
  import sprite_tile_fetcher_pkg::*;
(
  input  logic [7:0]         i_tile,
  input  logic [3:0]         i_line,
  input  logic               i_yflip,
  input  logic               i_obj_size,
  input  logic               i_plane,
  output logic [VRAM_AW-1:0] o_addr
);

  logic [3:0] w_r4;
  logic [2:0] w_row;
  logic [7:0] w_tile;

  // 15 - line has 7 - line[2:0] in its low bits, so one flipped value serves both sizes
  assign w_r4   = i_yflip ? (4'd15 - i_line) : i_line;
  assign w_row  = w_r4[2:0];
  // 8x16 sprites: even tile is the top half, odd tile the bottom half
  assign w_tile = i_obj_size ? {i_tile[7:1], w_r4[3]} : i_tile;
  assign o_addr = {1'b0, w_tile, w_row, i_plane};

endmodule

// File: rtl/sprite_tile_fetcher.sv
// Sprite tile fetcher: latches sprite params, reads low/high planes, hands them to the shifter.
// Latency: 3 cycles from accepted fetch_req to spr_load with zero-wait acks; +1 per wait cycle.
// Backpressure: holds vram_req/vram_addr until vram_ack; fetch_req ignored while busy.
module sprite_tile_fetcher
  import sprite_tile_fetcher_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               fetch_abort,
  input  logic [7:0]         spr_tile,
  input  logic [3:0]         spr_line,
  input  logic [7:0]         spr_attr,
  input  logic               obj_size,
  output logic               vram_req,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic               vram_ack,
  input  logic [7:0]         vram_data,
  output logic               fetch_busy,
  output logic [7:0]         spr_pix_a,
  output logic [7:0]         spr_pix_b,
  output logic               spr_pal,
  output logic               spr_prio,
  output logic               spr_load
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  // latched sprite parameters
  logic [7:0] r_tile;
  logic [3:0] r_line;
  logic       r_yflip;
  logic       r_xflip;
  logic       r_pal_l;
  logic       r_prio_l;
  logic       r_obj_size;

  logic [7:0]         r_plane_lo;
  logic [VRAM_AW-1:0] r_vram_addr;
  logic [7:0]         r_pix_a;
  logic [7:0]         r_pix_b;
  logic               r_pal;
  logic               r_prio;

  logic               w_accept;
  logic               w_cap_lo;
  logic               w_cap_hi;
  logic               w_in_idle;
  logic [7:0]         w_addr_tile;
  logic [3:0]         w_addr_line;
  logic               w_addr_yflip;
  logic               w_addr_size;
  logic               w_addr_plane;
  logic [VRAM_AW-1:0] w_addr;
  logic [7:0]         w_data_oriented;
  logic               w_unused_attr;

  // priority/palette/flip bits are the only attribute bits this block needs
  assign w_unused_attr = ^spr_attr[3:0];

  assign w_in_idle = (r_state == ST_IDLE);

  // In IDLE the address is built from the live inputs so it is ready the
  // cycle RD_LO is entered; afterwards the latched copies feed plane 1.
  assign w_addr_tile  = w_in_idle ? spr_tile : r_tile;
  assign w_addr_line  = w_in_idle ? spr_line : r_line;
  assign w_addr_yflip = w_in_idle ? spr_attr[ATTR_YFLIP] : r_yflip;
  assign w_addr_size  = w_in_idle ? obj_size : r_obj_size;
  assign w_addr_plane = ~w_in_idle;

  sprite_tile_addr u_addr (
    .i_tile     (w_addr_tile),
    .i_line     (w_addr_line),
    .i_yflip    (w_addr_yflip),
    .i_obj_size (w_addr_size),
    .i_plane    (w_addr_plane),
    .o_addr     (w_addr)
  );

  assign w_data_oriented = r_xflip ? bit_reverse8(vram_data) : vram_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and capture enables; abort beats a same-cycle ack
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_cap_lo     = 1'b0;
    w_cap_hi     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req) begin
          w_accept     = 1'b1;
          w_next_state = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        if (fetch_abort) begin
          w_next_state = ST_IDLE;
        end else if (vram_ack) begin
          w_cap_lo     = 1'b1;
          w_next_state = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        if (fetch_abort) begin
          w_next_state = ST_IDLE;
        end else if (vram_ack) begin
          w_cap_hi     = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Parameter latch, plane capture and shifter-facing output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tile      <= 8'h00;
      r_line      <= 4'h0;
      r_yflip     <= 1'b0;
      r_xflip     <= 1'b0;
      r_pal_l     <= 1'b0;
      r_prio_l    <= 1'b0;
      r_obj_size  <= 1'b0;
      r_plane_lo  <= 8'h00;
      r_vram_addr <= '0;
      r_pix_a     <= 8'h00;
      r_pix_b     <= 8'h00;
      r_pal       <= 1'b0;
      r_prio      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tile      <= spr_tile;
        r_line      <= spr_line;
        r_yflip     <= spr_attr[ATTR_YFLIP];
        r_xflip     <= spr_attr[ATTR_XFLIP];
        r_pal_l     <= spr_attr[ATTR_PAL];
        r_prio_l    <= spr_attr[ATTR_PRIO];
        r_obj_size  <= obj_size;
        r_vram_addr <= w_addr;
      end
      if (w_cap_lo) begin
        r_plane_lo  <= w_data_oriented;
        r_vram_addr <= w_addr;
      end
      // outputs only change on a completed fetch, so an aborted one leaves them intact
      if (w_cap_hi) begin
        r_pix_a <= r_plane_lo;
        r_pix_b <= w_data_oriented;
        r_pal   <= r_pal_l;
        r_prio  <= r_prio_l;
      end
    end
  end

  assign vram_req   = (r_state == ST_RD_LO) || (r_state == ST_RD_HI);
  assign vram_addr  = r_vram_addr;
  assign fetch_busy = ~w_in_idle;
  assign spr_load   = (r_state == ST_LOAD);
  assign spr_pix_a  = r_pix_a;
  assign spr_pix_b  = r_pix_b;
  assign spr_pal    = r_pal;
  assign spr_prio   = r_prio;

endmodule
